// File: rtl/romulus_round_sequencer_pkg.sv
// Shared configuration for the Romulus round sequencer: default geometry and FSM encodings.
package romulus_round_sequencer_pkg;

    localparam int CLKS_PER_RND_DEF = 4;
    localparam int ROUNDS_DEF       = 40;
    localparam int CONSTW_DEF       = 6;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } seq_state_t;

endpackage

// File: rtl/romulus_round_sequencer_if.sv
// Control/status bundle between the top-level Romulus controller and the round sequencer.
interface romulus_round_sequencer_if
    import romulus_round_sequencer_pkg::*;
#(
    parameter int CLKS_PER_RND = CLKS_PER_RND_DEF,
    parameter int CONSTW       = CONSTW_DEF
);
    logic                    start;
    logic                    hold;
    logic                    busy;
    logic                    done;
    logic                    tbc_en;
    logic [CLKS_PER_RND-1:0] ring_en;
    logic [CONSTW-1:0]       constant;
    logic [5:0]              round;

    modport master (
        output start, hold,
        input  busy, done, tbc_en, ring_en, constant, round
    );

    modport slave (
        input  start, hold,
        output busy, done, tbc_en, ring_en, constant, round
    );
endinterface

// File: rtl/skinny_rc_lfsr.sv
// Skinny-128-384+ round-constant LFSR with load/step controls; holds when neither is asserted.
module skinny_rc_lfsr
    import romulus_round_sequencer_pkg::*;
#(
    parameter int W = CONSTW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] rc
);
    logic [W-1:0] rc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_reg <= '0;
        end else if (load) begin
            rc_reg <= W'(1);
        end else if (step) begin
            rc_reg <= {rc_reg[W-2:0], rc_reg[W-1] ^ rc_reg[W-2] ^ 1'b1};
        end
    end

    assign rc = rc_reg;
endmodule

// File: rtl/romulus_round_sequencer.sv
// Sequences one full Skinny TBC call: ring position, round counter, round constant, stall and done.
module romulus_round_sequencer
    import romulus_round_sequencer_pkg::*;
#(
    parameter int CLKS_PER_RND = CLKS_PER_RND_DEF,
    parameter int ROUNDS       = ROUNDS_DEF,
    parameter int CONSTW       = CONSTW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    romulus_round_sequencer_if.slave  sif
);
    seq_state_t              state_reg, state_next;
    logic [CLKS_PER_RND-1:0] pos_reg;
    logic [5:0]              round_reg;
    logic [CONSTW-1:0]       rc;
    logic [CLKS_PER_RND-1:0] ring_en_w;

    logic run, load, adv, rnd_step, final_step;

    assign run        = (state_reg == ST_RUN);
    // start outside RUN reloads the call, which covers both IDLE->RUN and DONE->RUN
    assign load       = sif.start && !run;
    assign adv        = run && !sif.hold;
    assign rnd_step   = adv && pos_reg[CLKS_PER_RND-1];
    assign final_step = rnd_step && (round_reg == 6'(ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (sif.start) state_next = ST_RUN;
            ST_RUN:  if (final_step) state_next = ST_DONE;
            ST_DONE: state_next = sif.start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_reg   <= '0;
            round_reg <= '0;
        end else if (load) begin
            pos_reg   <= CLKS_PER_RND'(1);
            round_reg <= '0;
        end else begin
            if (adv) pos_reg <= {pos_reg[CLKS_PER_RND-2:0], pos_reg[CLKS_PER_RND-1]};
            if (rnd_step) round_reg <= round_reg + 6'd1;
        end
    end

    skinny_rc_lfsr #(.W(CONSTW)) u_rc_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (rnd_step),
        .rc   (rc)
    );

    // hold gates the enables combinationally so a stall takes effect in the same cycle
    assign sif.tbc_en = adv;

    for (genvar gi = 0; gi < CLKS_PER_RND; gi++) begin : g_ring
        assign ring_en_w[gi] = adv & pos_reg[gi];
    end

    assign sif.ring_en  = ring_en_w;
    assign sif.busy     = run;
    assign sif.done     = (state_reg == ST_DONE);
    assign sif.constant = run ? rc : '0;
    assign sif.round    = run ? round_reg : 6'd0;
endmodule
